// File: rtl/dis_pal_line_fetch.sv
// PAL line prefetch: fetches each active line one line ahead from the frame
// buffer via an Avalon burst master into the display line FIFO.
module dis_pal_line_fetch #(
   parameter int DATA_WIDTH  = 10,
   parameter int ADDR_WIDTH  = 24,
   parameter int DIS_X       = 720,
   parameter int BURST_LEN   = 16,
   parameter int LINE_STRIDE = 1024,
   parameter int FIFO_AW     = 10,
   parameter int FETCH_X     = 0
) (
   input  logic                  dis_clk,
   input  logic                  dis_rst_n,
   input  logic [9:0]            if_cnt_x,
   input  logic [9:0]            if_cnt_y,
   input  logic [ADDR_WIDTH-1:0] frame_base,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   output logic [7:0]            avm_burstcount,
   input  logic                  avm_waitrequest,
   input  logic                  avm_readdatavalid,
   input  logic [DATA_WIDTH-1:0] avm_readdata,
   input  logic [FIFO_AW:0]      fifo_usedw,
   output logic                  fifo_wrreq,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_sclr,
   output logic                  line_late,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

   localparam int OW = FIFO_AW + 1;
   localparam int CW = FIFO_AW + 3;
   localparam logic [CW-1:0] DEPTH = CW'(2**FIFO_AW);
   localparam logic [CW-1:0] BL_C  = CW'(BURST_LEN);
   localparam logic [OW-1:0] BL_O  = OW'(BURST_LEN);

   state_t                  state_q, state_d;
   logic [OW-1:0]           out_q, out_d;
   logic [9:0]              words_q, words_d;
   logic [ADDR_WIDTH-1:0]   addr_d, frame_base_q, start_addr;
   logic                    read_d, late_d;
   logic [9:0]              row;
   logic                    frame_start, trigger, accept, rd_beat, credit_ok;

   assign frame_start = (if_cnt_x == 10'd0) && (if_cnt_y == 10'd0);
   assign trigger = (if_cnt_x == 10'(FETCH_X)) &&
                    (((if_cnt_y >= 10'd21) && (if_cnt_y <= 10'd308)) ||
                     ((if_cnt_y >= 10'd334) && (if_cnt_y <= 10'd621)));

   // Field 0 lands on even frame rows, field 1 on odd rows.
   always_comb begin
      if (if_cnt_y <= 10'd308) row = (if_cnt_y - 10'd21) << 1;
      else                     row = ((if_cnt_y - 10'd334) << 1) | 10'd1;
   end

   assign start_addr = frame_base_q + ADDR_WIDTH'(row) * ADDR_WIDTH'(LINE_STRIDE);

   assign accept  = avm_read & ~avm_waitrequest;
   // Beats with nothing outstanding are stale (e.g. issued before a reset).
   assign rd_beat = avm_readdatavalid & (out_q != '0);
   assign out_d   = out_q + (accept ? BL_O : '0) - OW'(rd_beat);
   assign credit_ok = (CW'(fifo_usedw) + CW'(out_d) + BL_C) <= DEPTH;

   always_comb begin
      state_d = state_q;
      words_d = words_q;
      addr_d  = avm_address;
      read_d  = avm_read;
      late_d  = line_late;
      if (accept) begin
         addr_d  = avm_address + ADDR_WIDTH'(BURST_LEN);
         words_d = words_q - 10'(BURST_LEN);
      end
      case (state_q)
         IDLE: if (trigger) begin
            state_d = FETCH;
            addr_d  = start_addr;
            words_d = 10'(DIS_X);
            read_d  = credit_ok;
         end
         FETCH: begin
            if (accept && (words_d == 10'd0)) begin
               state_d = DRAIN;
               read_d  = 1'b0;
            end else if (!(avm_read && avm_waitrequest)) begin
               read_d = credit_ok;
            end
         end
         DRAIN: if (out_d == '0) state_d = IDLE;
         FLUSH: begin
            if (accept) read_d = 1'b0;
            if ((out_d == '0) && !read_d) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (trigger && (state_q != IDLE)) late_d = 1'b1;
      // A request already stalled on the bus must still complete.
      if (frame_start && (state_q != IDLE)) begin
         state_d = FLUSH;
         read_d  = avm_read & avm_waitrequest;
      end
   end

   always_ff @(posedge dis_clk or negedge dis_rst_n) begin
      if (!dis_rst_n) begin
         state_q      <= IDLE;
         out_q        <= '0;
         words_q      <= '0;
         avm_address  <= '0;
         avm_read     <= 1'b0;
         line_late    <= 1'b0;
         frame_base_q <= '0;
         fifo_wrreq   <= 1'b0;
         fifo_data    <= '0;
         fifo_sclr    <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         words_q     <= words_d;
         avm_address <= addr_d;
         avm_read    <= read_d;
         line_late   <= late_d;
         if (frame_start) frame_base_q <= frame_base;
         fifo_wrreq  <= rd_beat & (state_q != FLUSH) & ~frame_start;
         fifo_data   <= avm_readdata;
         fifo_sclr   <= frame_start;
      end
   end

   assign busy           = (state_q != IDLE);
   assign avm_burstcount = 8'(BURST_LEN);

endmodule

// File: tb/tb_dis_pal_line_fetch.sv
// Directed bench for dis_pal_line_fetch with a burst slave model and
// address/data scoreboards.
module tb_dis_pal_line_fetch;

   logic        dis_clk = 1'b0;
   logic        dis_rst_n;
   logic [9:0]  if_cnt_x, if_cnt_y;
   logic [23:0] frame_base;
   logic [23:0] avm_address;
   logic        avm_read;
   logic [7:0]  avm_burstcount;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [9:0]  avm_readdata;
   logic [10:0] fifo_usedw;
   logic        fifo_wrreq;
   logic [9:0]  fifo_data;
   logic        fifo_sclr;
   logic        line_late;
   logic        busy;

   dis_pal_line_fetch dut (
      .dis_clk(dis_clk), .dis_rst_n(dis_rst_n),
      .if_cnt_x(if_cnt_x), .if_cnt_y(if_cnt_y), .frame_base(frame_base),
      .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
      .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
      .avm_readdata(avm_readdata), .fifo_usedw(fifo_usedw), .fifo_wrreq(fifo_wrreq),
      .fifo_data(fifo_data), .fifo_sclr(fifo_sclr), .line_late(line_late), .busy(busy)
   );

   always #5 dis_clk = ~dis_clk;

   int          total = 0, bad = 0;
   int          wr_cnt = 0, n_acc = 0, stall_cnt = 0;
   bit          mute = 0, drop = 0, stall_prev = 0;
   logic [23:0] prev_addr, base_m = '0;
   logic [23:0] exp_a[$];
   logic [9:0]  exp_d[$];
   logic [9:0]  mem_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] row_addr(input int y, input logic [23:0] base);
      int r;
      r = (y <= 308) ? 2 * (y - 21) : 2 * (y - 334) + 1;
      return base + 24'(r * 1024);
   endfunction

   // One cycle: observe registered outputs, then drive slave inputs for the next edge.
   task automatic tick();
      @(negedge dis_clk);
      if (fifo_wrreq) begin
         wr_cnt++;
         if (exp_d.size() == 0) chk("wr_extra", 32'(exp_d.size()), 32'd1);
         else chk("wr_data", 32'(fifo_data), 32'(exp_d.pop_front()));
      end
      if (stall_prev) begin
         chk("stall_read", 32'(avm_read), 32'd1);
         chk("stall_addr", 32'(avm_address), 32'(prev_addr));
      end
      if (!mute && mem_q.size() > 0) begin
         avm_readdatavalid = 1'b1;
         avm_readdata = mem_q.pop_front();
         if (!drop) exp_d.push_back(avm_readdata);
      end else begin
         avm_readdatavalid = 1'b0;
      end
      avm_waitrequest = (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      stall_prev = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (avm_read && !avm_waitrequest) begin
         n_acc++;
         if (exp_a.size() == 0) chk("addr_extra", 32'(exp_a.size()), 32'd1);
         else chk("burst_addr", 32'(avm_address), 32'(exp_a.pop_front()));
         for (int i = 0; i < 16; i++) mem_q.push_back(10'(avm_address + 24'(i)));
      end
   endtask

   task automatic trig(input int y, input bit push);
      if (push) for (int k = 0; k < 45; k++) exp_a.push_back(row_addr(y, base_m) + 24'(16 * k));
      if_cnt_y = 10'(y);
      if_cnt_x = 10'd0;
      tick();
      if_cnt_x = 10'd100;
   endtask

   task automatic fstart();
      base_m = frame_base;
      if_cnt_y = 10'd0;
      if_cnt_x = 10'd0;
      tick();
      chk("sclr_pulse", 32'(fifo_sclr), 32'd1);
      if_cnt_y = 10'd5;
      if_cnt_x = 10'd100;
      tick();
      chk("sclr_end", 32'(fifo_sclr), 32'd0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || mem_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
      repeat (3) tick();
   endtask

   initial begin
      int w0, a0;
      dis_rst_n = 1'b0;
      if_cnt_x = 10'd100;
      if_cnt_y = 10'd5;
      frame_base = '0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      fifo_usedw = '0;
      repeat (2) tick();
      chk("rst_read", 32'(avm_read), 32'd0);
      chk("rst_addr", 32'(avm_address), 32'd0);
      chk("rst_burstcount", 32'(avm_burstcount), 32'd16);
      chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("rst_sclr", 32'(fifo_sclr), 32'd0);
      chk("rst_late", 32'(line_late), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      dis_rst_n = 1'b1;
      tick();

      // basic fetch, field 0 line 22 -> row 0
      frame_base = 24'h1000;
      fstart();
      chk("idle_after_sclr", 32'(busy), 32'd0);
      w0 = wr_cnt; a0 = n_acc;
      trig(21, 1);
      chk("first_req", 32'(avm_read), 32'd1);
      chk("first_addr", 32'(avm_address), 32'h1000);
      chk("busy_on", 32'(busy), 32'd1);
      wait_idle("basic");
      chk("basic_wr", 32'(wr_cnt - w0), 32'd720);
      chk("basic_bursts", 32'(n_acc - a0), 32'd45);
      chk("basic_busy_off", 32'(busy), 32'd0);

      // field 1 mapping
      trig(334, 1);
      chk("f1_addr", 32'(avm_address), 32'h1400);
      wait_idle("f1_first");
      trig(621, 1);
      chk("f1_last_addr", 32'(avm_address), 32'h1000 + 32'(575 * 1024));
      wait_idle("f1_last");

      // credit throttling and stall stability
      w0 = wr_cnt; a0 = n_acc;
      mute = 1;
      fifo_usedw = 11'd1010;
      trig(22, 1);
      chk("credit_block0", 32'(avm_read), 32'd0);
      chk("credit_busy", 32'(busy), 32'd1);
      repeat (5) tick();
      chk("credit_block1", 32'(avm_read), 32'd0);
      fifo_usedw = 11'd1008;
      tick();
      chk("credit_edge", 32'(avm_read), 32'd1);
      tick();
      chk("credit_out16", 32'(avm_read), 32'd0);
      chk("addr_step", 32'(avm_address), 32'(row_addr(22, base_m) + 24'd16));
      repeat (2) tick();
      chk("credit_hold", 32'(avm_read), 32'd0);
      fifo_usedw = 11'd992;
      stall_cnt = 5;
      tick();
      chk("credit_out16_ok", 32'(avm_read), 32'd1);
      repeat (6) tick();
      chk("credit_out32", 32'(avm_read), 32'd0);
      chk("stall_bursts", 32'(n_acc - a0), 32'd2);
      fifo_usedw = '0;
      mute = 0;
      wait_idle("credit");
      chk("credit_wr", 32'(wr_cnt - w0), 32'd720);
      chk("credit_bursts", 32'(n_acc - a0), 32'd45);

      // frame flush with two bursts outstanding
      a0 = n_acc;
      mute = 1;
      fifo_usedw = 11'd992;
      trig(30, 1);
      repeat (4) tick();
      chk("flush_bursts", 32'(n_acc - a0), 32'd2);
      chk("flush_pending", 32'(mem_q.size()), 32'd32);
      exp_a.delete();
      w0 = wr_cnt;
      base_m = frame_base;
      if_cnt_y = 10'd0;
      if_cnt_x = 10'd0;
      tick();
      chk("flush_sclr", 32'(fifo_sclr), 32'd1);
      chk("flush_busy", 32'(busy), 32'd1);
      if_cnt_y = 10'd5;
      if_cnt_x = 10'd100;
      drop = 1;
      mute = 0;
      fifo_usedw = '0;
      tick();
      chk("flush_sclr_end", 32'(fifo_sclr), 32'd0);
      wait_idle("flush");
      chk("flush_no_wr", 32'(wr_cnt - w0), 32'd0);
      chk("flush_idle", 32'(busy), 32'd0);
      drop = 0;

      // frame base change applies only after the next frame start
      frame_base = 24'h40000;
      trig(100, 1);
      chk("base_old", 32'(avm_address), 32'(row_addr(100, 24'h1000)));
      wait_idle("base_old");
      fstart();
      trig(21, 1);
      chk("base_new", 32'(avm_address), 32'h40000);
      wait_idle("base_new");

      // late line: slave withholds data, next trigger arrives in DRAIN
      mute = 1;
      trig(40, 1);
      repeat (60) tick();
      chk("late_all_bursts", 32'(exp_a.size()), 32'd0);
      chk("late_pre", 32'(line_late), 32'd0);
      a0 = n_acc;
      trig(41, 0);
      chk("late_set", 32'(line_late), 32'd1);
      repeat (20) tick();
      chk("late_sticky", 32'(line_late), 32'd1);
      chk("late_no_burst", 32'(n_acc - a0), 32'd0);
      chk("late_busy", 32'(busy), 32'd1);

      // mid-operation reset; in-flight beats afterwards must be dropped
      dis_rst_n = 1'b0;
      #1;
      chk("mrst_late", 32'(line_late), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_read", 32'(avm_read), 32'd0);
      tick();
      dis_rst_n = 1'b1;
      w0 = wr_cnt;
      drop = 1;
      mute = 0;
      wait_idle("mrst");
      chk("mrst_no_wr", 32'(wr_cnt - w0), 32'd0);
      chk("mrst_late_clear", 32'(line_late), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
